latticehx1k_clkgen: RTL and testbench

Parametrised clock-management successor to the fixed single-output iCE40 PLL wrapper. Sits directly behind the PLL's 48 MHz core clock and gates the design on PLL lock with a settle interval. Supplies a synchronous downstream reset and NUM_CH independently programmable clock-enable tick channels, e.g. 1 kHz scan, 1 Hz clock, UART baud. All outputs are in the `clk` domain; no derived clocks are generated.

---
 rtl/latticehx1k_clkgen.sv | 187 ++++++++++++++++++
 tb/tb_latticehx1k_clkgen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/latticehx1k_clkgen.sv
// Purpose: gates the design on a settled PLL lock, drives a synchronous downstream reset and NUM_CH programmable clock-enable tick channels.
// Latency: ready/sys_rst_n rise 2+LOCK_SETTLE edges after lock is first sampled; first tick arrives div edges after a channel starts counting.
// Backpressure: none; divisor writes to a running channel wait for its next wrap so no period is truncated.
// Optional feature: define CLKGEN_LOCK_BYPASS_EN to ignore pll_lock and treat the PLL as always locked.
module latticehx1k_clkgen #(
   parameter int CLK_HZ      = 48_000_000,
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 24,
   parameter int LOCK_SETTLE = 1024,
   parameter int DEFAULT_DIV = CLK_HZ / 1000,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pll_lock,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] tick,
   output logic              ready,
   output logic              sys_rst_n
);

   localparam int SET_W = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_SETTLE - 1);
   localparam logic [DIV_W-1:0] DEF_DIV  = DIV_W'(DEFAULT_DIV);

   localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
   localparam logic [1:0] ST_SETTLE    = 2'd1;
   localparam logic [1:0] ST_RUN       = 2'd2;

   logic                        lock_in;
   logic                        sync1_q, sync1_d;
   logic                        sync2_q, sync2_d;
   logic [1:0]                  state_q, state_d;
   logic [SET_W-1:0]            set_cnt_q, set_cnt_d;
   logic                        ready_q, ready_d;
   logic                        sys_rst_n_q, sys_rst_n_d;
   logic [NUM_CH-1:0]           tick_q, tick_d;
   logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d;
   logic [NUM_CH-1:0][DIV_W-1:0] pend_q, pend_d;
   logic [NUM_CH-1:0]           pend_vld_q, pend_vld_d;
   logic                        run_now, run_nxt;

`ifdef CLKGEN_LOCK_BYPASS_EN
   // The simulation PLL model never drives LOCK; feed a constant high through the synchroniser
   // so release still waits the synchroniser delay plus the settle interval after reset.
   logic unused_pll_lock;
   assign unused_pll_lock = pll_lock;
   assign lock_in         = 1'b1;
`else
   assign lock_in = pll_lock;
`endif

   // Two-flop synchroniser for the asynchronous lock input
   always_comb begin
      sync1_d = lock_in;
      sync2_d = sync1_q;
   end

   // Lock qualification FSM: wait for lock, require LOCK_SETTLE stable cycles, then run
   always_comb begin
      state_d   = state_q;
      set_cnt_d = '0;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (sync2_q) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!sync2_q) begin
               state_d = ST_WAIT_LOCK;
            end else if (set_cnt_q == SET_LAST) begin
               state_d = ST_RUN;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (!sync2_q) state_d = ST_WAIT_LOCK;
         end
         default: state_d = ST_WAIT_LOCK;
      endcase
   end

   assign run_now = (state_q == ST_RUN);
   assign run_nxt = (state_d == ST_RUN);

   // ready and the downstream reset follow the state being entered so they line up with RUN
   always_comb begin
      ready_d     = run_nxt;
      sys_rst_n_d = run_nxt;
   end

   // Per-channel counters, tick generation and wrap-aligned divisor updates
   always_comb begin
      cnt_d      = cnt_q;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      tick_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         logic wr, active, wrap;
         wr     = cfg_we && (32'(cfg_ch) == i);
         active = run_now && ch_en[i] && (div_q[i] != '0);
         wrap   = active && (cnt_q[i] == div_q[i] - DIV_W'(1));

         // Counter: idle channels and anything leaving RUN sit at zero
         if (!run_nxt || !active) begin
            cnt_d[i] = '0;
         end else if (wrap) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
         end

         // Divisor: a running channel only changes period at a wrap; a write landing on
         // the wrap itself wins over an older pending value.
         if (active) begin
            if (wrap) begin
               if (wr) begin
                  div_d[i]      = cfg_div;
                  pend_vld_d[i] = 1'b0;
               end else if (pend_vld_q[i]) begin
                  div_d[i]      = pend_q[i];
                  pend_vld_d[i] = 1'b0;
               end
            end else if (wr) begin
               pend_d[i]     = cfg_div;
               pend_vld_d[i] = 1'b1;
            end
         end else begin
            // Counter is parked at zero, so a new value (or a leftover pending one) is safe now
            if (wr) begin
               div_d[i]      = cfg_div;
               pend_vld_d[i] = 1'b0;
            end else if (pend_vld_q[i]) begin
               div_d[i]      = pend_q[i];
               pend_vld_d[i] = 1'b0;
            end
         end
      end
   end

   // Control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= ST_WAIT_LOCK;
         set_cnt_q   <= '0;
         ready_q     <= 1'b0;
         sys_rst_n_q <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         set_cnt_q   <= set_cnt_d;
         ready_q     <= ready_d;
         sys_rst_n_q <= sys_rst_n_d;
      end
   end

   // Channel registers; divisors return to the default on reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_q     <= '0;
         cnt_q      <= '0;
         div_q      <= {NUM_CH{DEF_DIV}};
         pend_q     <= '0;
         pend_vld_q <= '0;
      end else begin
         tick_q     <= tick_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
      end
   end

   assign tick      = tick_q;
   assign ready     = ready_q;
   assign sys_rst_n = sys_rst_n_q;

endmodule

// File: tb/tb_latticehx1k_clkgen.sv
// Directed bench for latticehx1k_clkgen: lock/settle release, tick periods, pending divisor writes,
// lock loss and relock, and synchronous reset mid-RUN. Three channels so that cfg_ch=3 is out of range.
module tb_latticehx1k_clkgen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_lock;
   logic       cfg_we;
   logic [1:0] cfg_ch;
   logic [7:0] cfg_div;
   logic [2:0] ch_en;
   logic [2:0] tick;
   logic       ready;
   logic       sys_rst_n;

   int tests = 0;
   int fails = 0;

   // ch0 div=2, ch1 div=3, ch2 div=0, all starting from counter 0
   logic [2:0] pat [6] = '{3'b000, 3'b001, 3'b010, 3'b001, 3'b000, 3'b011};

   always #5 clk = ~clk;

   latticehx1k_clkgen #(
      .CLK_HZ(4000), .NUM_CH(3), .DIV_W(8), .LOCK_SETTLE(8), .DEFAULT_DIV(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .ch_en(ch_en), .tick(tick), .ready(ready), .sys_rst_n(sys_rst_n)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; pll_lock = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0; ch_en = 3'b000;
      repeat (3) cyc();
      chk("rst_ready", 8'(ready), 8'h00);
      chk("rst_sys_rst_n", 8'(sys_rst_n), 8'h00);
      chk("rst_tick", 8'(tick), 8'h00);

      rst_n = 1'b1;
      repeat (2) cyc();
      chk("nolock_ready", 8'(ready), 8'h00);

      // Lock sampled at edge k; release at edge k+10
      pll_lock = 1'b1; ch_en = 3'b001;
      for (int j = 0; j < 10; j++) begin
         cyc();
         chk("settle_ready", 8'(ready), 8'h00);
         chk("settle_tick", 8'(tick), 8'h00);
      end
      cyc();
      chk("run_ready", 8'(ready), 8'h01);
      chk("run_sys_rst_n", 8'(sys_rst_n), 8'h01);
      chk("run_tick", 8'(tick), 8'h00);

      // Default divisor 4 on ch0 only
      for (int j = 1; j <= 8; j++) begin
         cyc();
         chk("div4_tick", 8'(tick), (j % 4 == 0) ? 8'h01 : 8'h00);
      end

      // Writes at counts 1 and 2: the second replaces the first, applied at the wrap
      cyc(); chk("wr_c1_tick", 8'(tick), 8'h00);
      cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
      cyc(); chk("wr_c2_tick", 8'(tick), 8'h00);
      cfg_div = 8'd2;
      cyc(); chk("wr_c3_tick", 8'(tick), 8'h00);
      cfg_we = 1'b0;
      cyc(); chk("old_period_wrap", 8'(tick), 8'h01);
      for (int j = 1; j <= 4; j++) begin
         cyc();
         chk("div2_tick", 8'(tick), (j % 2 == 0) ? 8'h01 : 8'h00);
      end

      // Immediate writes to inactive channels, including an out-of-range index
      ch_en = 3'b000;
      cfg_we = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd0; cyc();
      cfg_div = 8'd3; cyc();
      cfg_ch = 2'd2; cfg_div = 8'd0; cyc();
      cfg_ch = 2'd3; cfg_div = 8'd7; cyc();
      cfg_we = 1'b0;
      chk("disabled_tick", 8'(tick), 8'h00);

      ch_en = 3'b010;
      cyc(); chk("ch1_e1", 8'(tick), 8'h00);
      cyc(); chk("ch1_e2", 8'(tick), 8'h00);
      cyc(); chk("ch1_first", 8'(tick), 8'h02);
      cyc(); chk("ch1_p1", 8'(tick), 8'h00);
      cyc(); chk("ch1_p2", 8'(tick), 8'h00);
      cyc(); chk("ch1_period", 8'(tick), 8'h02);

      ch_en = 3'b111;
      for (int j = 0; j < 6; j++) begin
         cyc();
         chk("mix_tick", 8'(tick), 8'(pat[j]));
      end

      // Lock drop sampled at edge m; outputs fall after m+2
      pll_lock = 1'b0;
      cyc(); chk("drop_m_ready", 8'(ready), 8'h01); chk("drop_m_tick", 8'(tick), 8'h00);
      cyc(); chk("drop_m1_ready", 8'(ready), 8'h01); chk("drop_m1_tick", 8'(tick), 8'h01);
      cyc();
      chk("drop_m2_ready", 8'(ready), 8'h00);
      chk("drop_m2_sys_rst_n", 8'(sys_rst_n), 8'h00);
      chk("drop_m2_tick", 8'(tick), 8'h00);

      // Relock: full settle again, divisors retained
      pll_lock = 1'b1;
      for (int j = 0; j < 10; j++) begin
         cyc();
         chk("resettle_ready", 8'(ready), 8'h00);
      end
      cyc(); chk("relock_ready", 8'(ready), 8'h01);
      for (int j = 0; j < 6; j++) begin
         cyc();
         chk("relock_mix", 8'(tick), 8'(pat[j]));
      end

      // ch2 from idle (div=0) to div=1: tick every cycle
      cfg_we = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd1;
      cyc(); chk("div1_w", 8'(tick), 8'h00);
      cfg_we = 1'b0;
      cyc(); chk("div1_a", 8'(tick), 8'h05);
      cyc(); chk("div1_b", 8'(tick), 8'h06);

      // Synchronous reset mid-RUN
      rst_n = 1'b0;
      cyc();
      chk("midrst_ready", 8'(ready), 8'h00);
      chk("midrst_sys_rst_n", 8'(sys_rst_n), 8'h00);
      chk("midrst_tick", 8'(tick), 8'h00);
      rst_n = 1'b1;
      for (int j = 0; j < 10; j++) begin
         cyc();
         chk("postrst_ready", 8'(ready), 8'h00);
      end
      cyc(); chk("postrst_run", 8'(ready), 8'h01);
      for (int j = 1; j <= 4; j++) begin
         cyc();
         chk("default_div_tick", 8'(tick), (j == 4) ? 8'h07 : 8'h00);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
